ay_bus_responder: RTL and testbench
===================================

// Module: ay_bus_responder
// PURPOSE
//  Slave end of the AY-8910 style BDIR/BC1/BC2 bus: reacts to the bus cycles produced
//  by the host-side decoder and turns them into paced chip accesses. Samples async bus
//  controls on fclk, latches the register number, handles chip-select control codes
//  (0xFE/0xFF) and emits YM write/read strobe sequences on the internal YM/SAA bus.
//  Sits inside TurboFMpro between the ay* pins and the ym* pins.
// PARAMETERS
//  WR_SETUP  1  fclk cycles from cs_n low / a0 and d valid to wr_n falling
//  WR_PULSE  4  fclk cycles wr_n is held low
//  WR_HOLD   2  fclk cycles cs_n, a0 and d are held after wr_n rises
// PORTS
//  fclk      in   1  28 MHz system clock; all logic on its rising edge
//  ayres_n   in   1  async active-low reset
//  aybdir    in   1  bus BDIR (async to fclk)
//  aybc1     in   1  bus BC1 (async)
//  aybc2     in   1  bus BC2 (async)
//  aya8      in   1  bus A8 (async)
//  aya9_n    in   1  bus A9, active low (async)
//  ayd_in    in   8  host data bus, input view
//  ayd_out   out  8  data returned to host during reads (= d_in, passed through)
//  ayd_oe    out  1  host data bus output enable
//  d_in      in   8  internal bus, input view (YM read data)
//  d_out     out  8  internal bus write data
//  d_oe      out  1  internal bus output enable
//  ymcs1_n   out  1  YM chip 1 select
//  ymcs2_n   out  1  YM chip 2 select
//  ymwr_n    out  1  YM write strobe
//  ymrd_n    out  1  YM read strobe
//  yma0      out  1  YM A0: 0 = address write, 1 = data write / status read
//  chip_sel  out  1  current chip: 0 = chip 1, 1 = chip 2
//  reg_num   out  8  last register number written through the address phase
// BEHAVIOUR
//  - Reset: all *_n outputs 1, ayd_oe = d_oe = 0, yma0 = 0, chip_sel = 0, reg_num = 0x00,
//    d_out = 0x00, FSM IDLE. Applying reset asynchronously deasserts all strobes at once,
//    even mid-cycle; there is no completion of an interrupted access.
//  - Sync: bdir and bc1 are each passed through a 2-FF synchronizer. A bus cycle is
//    valid only when bc2 = 1, a8 = 1 and a9_n = 0, sampled via the same 2-FF chain.
//  - Mode from synced {bdir,bc1}: 11 = ADDR write, 10 = DATA write, 01 = READ, 00 = IDLE.
//  - A mode must be stable for 2 consecutive synced samples before it is accepted. The
//    first fclk edge after acceptance latches ayd_in.
//  - Each mode runs at most one operation. A new operation needs synced mode = 00 first.
//  - ADDR with value 0xFE: chip_sel <= 1. ADDR with 0xFF: chip_sel <= 0. Neither value
//    produces a YM cycle, and reg_num is unchanged.
//  - Any other ADDR value v: reg_num <= v, then a YM write with yma0 = 0 and d_out = v.
//  - DATA value v: a YM write with yma0 = 1 and d_out = v.
//  - Write FSM: IDLE -> SETUP (WR_SETUP cyc: cs_n low, d_oe = 1) -> STROBE (WR_PULSE cyc:
//    wr_n low) -> HOLD (WR_HOLD cyc: cs_n low, d_oe = 1) -> IDLE.
//    The active cs is ymcs1_n when chip_sel = 0, ymcs2_n when chip_sel = 1. chip_sel is
//    frozen for the whole cycle.
//  - If the host bus returns to idle before the write sequence ends, the sequence still
//    completes in full.
//  - If a new mode is accepted while the FSM is busy, the operation waits. It starts in
//    the cycle after HOLD ends. The queue depth is 1; a further arrival overwrites the
//    pending entry.
//  - READ: state RD. Entered only from IDLE. Drives yma0 = 1, active cs_n = 0, ymrd_n = 0
//    and ayd_oe = 1 with ayd_out = d_in. Held while synced mode = 01. When the mode leaves
//    01, all of these deassert on the next edge. d_oe = 0 throughout.
//  - Mode 00, or an invalid bc2/a8/a9_n combination: no strobes and no state change.
//    An invalid combination arriving mid-sequence does not abort a write already started.
//  - ymwr_n and ymrd_n are never low at the same time. ymcs1_n and ymcs2_n are never low
//    at the same time.
// TESTING
//  1. Reset, then iowr FFFD = 0x27: one ymcs1_n pulse, ymwr_n low exactly 4 fclk,
//     yma0 = 0, d_out = 0x27, reg_num = 0x27.
//  2. iowr BFFD = 0x55: one write with yma0 = 1, d_out = 0x55. ymwr_n falls 1 fclk after
//     ymcs1_n; cs is released 2 fclk after ymwr_n rises.
//  3. iowr FFFD = 0xFE: no ymwr_n pulse and chip_sel = 1. Then iowr BFFD = 0xAA: the
//     strobe appears on ymcs2_n only. Then FFFD = 0xFF returns chip_sel to 0.
//  4. iord FFFD with d_in = 0x80: ymrd_n and ymcs1_n low, ayd_oe = 1, host reads 0x80.
//     All released within 3 fclk after rd_n rises.
//  5. Assert ayres_n during the STROBE state: ymwr_n, cs_n and d_oe go inactive with no
//     clock edge. After release there is no spurious strobe.
//  6. bc2 = 0 (or a8 = 0) during iowr FFFD = 0x12: no YM activity and reg_num unchanged.

Source files
------------

// File: rtl/ay_bus_responder.sv
// Slave side of the AY-8910 BDIR/BC1/BC2 bus: synchronises host bus cycles and
// turns them into paced YM write/read strobe sequences on the internal bus.
module ay_bus_responder #(
  parameter int WR_SETUP = 1,
  parameter int WR_PULSE = 4,
  parameter int WR_HOLD  = 2
) (
  input  logic       fclk,
  input  logic       ayres_n,
  input  logic       aybdir,
  input  logic       aybc1,
  input  logic       aybc2,
  input  logic       aya8,
  input  logic       aya9_n,
  input  logic [7:0] ayd_in,
  output logic [7:0] ayd_out,
  output logic       ayd_oe,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic       d_oe,
  output logic       ymcs1_n,
  output logic       ymcs2_n,
  output logic       ymwr_n,
  output logic       ymrd_n,
  output logic       yma0,
  output logic       chip_sel,
  output logic [7:0] reg_num
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RD} state_t;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_READ = 2'b01;
  localparam logic [1:0] MODE_DATA = 2'b10;
  localparam logic [1:0] MODE_ADDR = 2'b11;

  state_t     state;
  logic [7:0] cnt;
  logic [4:0] sync1, sync2;
  logic [1:0] mode, mode_prev;
  logic       bus_valid, armed, accept;
  logic       pend_valid;
  logic [1:0] pend_mode;
  logic [7:0] pend_data;
  logic       is_cs_code, start_wr, start_rd;

  // Sync vector layout: {bdir, bc1, bc2, a8, a9_n}
  always_ff @(posedge fclk or negedge ayres_n) begin
    if (!ayres_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {aybdir, aybc1, aybc2, aya8, aya9_n};
      sync2 <= sync1;
    end
  end

  assign bus_valid = sync2[2] & sync2[1] & ~sync2[0];
  assign mode      = bus_valid ? sync2[4:3] : MODE_IDLE;
  assign accept    = armed && (mode != MODE_IDLE) && (mode == mode_prev);

  // One operation per host cycle: re-arm only after the bus has been seen idle.
  always_ff @(posedge fclk or negedge ayres_n) begin
    if (!ayres_n) begin
      mode_prev <= MODE_IDLE;
      armed     <= 1'b1;
    end else begin
      mode_prev <= mode;
      if (mode == MODE_IDLE)
        armed <= 1'b1;
      else if (accept)
        armed <= 1'b0;
    end
  end

  assign is_cs_code = (pend_data == 8'hFE) || (pend_data == 8'hFF);
  assign start_wr   = (state == IDLE) && pend_valid &&
                      ((pend_mode == MODE_DATA) || ((pend_mode == MODE_ADDR) && !is_cs_code));
  assign start_rd   = (state == IDLE) && pend_valid && (pend_mode == MODE_READ);
  assign ayd_out    = d_in;

  always_ff @(posedge fclk or negedge ayres_n) begin
    if (!ayres_n) begin
      state      <= IDLE;
      cnt        <= '0;
      pend_valid <= 1'b0;
      pend_mode  <= MODE_IDLE;
      pend_data  <= '0;
      chip_sel   <= 1'b0;
      reg_num    <= '0;
      d_out      <= '0;
      d_oe       <= 1'b0;
      ayd_oe     <= 1'b0;
      ymcs1_n    <= 1'b1;
      ymcs2_n    <= 1'b1;
      ymwr_n     <= 1'b1;
      ymrd_n     <= 1'b1;
      yma0       <= 1'b0;
    end else begin
      // A fresh acceptance overwrites whatever is still pending.
      if (state == IDLE && pend_valid)
        pend_valid <= 1'b0;
      if (accept) begin
        pend_valid <= 1'b1;
        pend_mode  <= mode;
        pend_data  <= ayd_in;
      end

      case (state)
        IDLE: begin
          if (pend_valid && pend_mode == MODE_ADDR && pend_data == 8'hFE)
            chip_sel <= 1'b1;
          if (pend_valid && pend_mode == MODE_ADDR && pend_data == 8'hFF)
            chip_sel <= 1'b0;
          if (start_wr) begin
            if (pend_mode == MODE_ADDR)
              reg_num <= pend_data;
            state   <= SETUP;
            cnt     <= 8'(WR_SETUP - 1);
            d_out   <= pend_data;
            d_oe    <= 1'b1;
            yma0    <= (pend_mode == MODE_DATA);
            ymcs1_n <= chip_sel;
            ymcs2_n <= ~chip_sel;
          end else if (start_rd) begin
            state   <= RD;
            yma0    <= 1'b1;
            ymrd_n  <= 1'b0;
            ayd_oe  <= 1'b1;
            ymcs1_n <= chip_sel;
            ymcs2_n <= ~chip_sel;
          end
        end
        SETUP: begin
          if (cnt == 8'd0) begin
            state  <= STROBE;
            cnt    <= 8'(WR_PULSE - 1);
            ymwr_n <= 1'b0;
          end else
            cnt <= cnt - 8'd1;
        end
        STROBE: begin
          if (cnt == 8'd0) begin
            state  <= HOLD;
            cnt    <= 8'(WR_HOLD - 1);
            ymwr_n <= 1'b1;
          end else
            cnt <= cnt - 8'd1;
        end
        HOLD: begin
          if (cnt == 8'd0) begin
            state   <= IDLE;
            d_oe    <= 1'b0;
            yma0    <= 1'b0;
            ymcs1_n <= 1'b1;
            ymcs2_n <= 1'b1;
          end else
            cnt <= cnt - 8'd1;
        end
        RD: begin
          if (mode != MODE_READ) begin
            state   <= IDLE;
            ymrd_n  <= 1'b1;
            ayd_oe  <= 1'b0;
            yma0    <= 1'b0;
            ymcs1_n <= 1'b1;
            ymcs2_n <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ay_bus_responder.sv
// Directed bench for ay_bus_responder: host bus cycles in, YM strobe timing checked
// against hand-computed values.
module tb_ay_bus_responder;

  logic       fclk = 1'b0;
  logic       ayres_n;
  logic       aybdir, aybc1, aybc2, aya8, aya9_n;
  logic [7:0] ayd_in, d_in;
  logic [7:0] ayd_out, d_out, reg_num;
  logic       ayd_oe, d_oe, ymcs1_n, ymcs2_n, ymwr_n, ymrd_n, yma0, chip_sel;

  int errors = 0;
  int checks = 0;

  int cyc, wr_low, cs1_falls, cs1_low, cs2_low, rd_low, conflicts;
  int first_cs, last_cs, first_wr, last_wr;
  logic [7:0] wr_data;
  logic       wr_a0, prev_cs1, found;

  ay_bus_responder dut (
    .fclk(fclk), .ayres_n(ayres_n), .aybdir(aybdir), .aybc1(aybc1), .aybc2(aybc2),
    .aya8(aya8), .aya9_n(aya9_n), .ayd_in(ayd_in), .ayd_out(ayd_out), .ayd_oe(ayd_oe),
    .d_in(d_in), .d_out(d_out), .d_oe(d_oe), .ymcs1_n(ymcs1_n), .ymcs2_n(ymcs2_n),
    .ymwr_n(ymwr_n), .ymrd_n(ymrd_n), .yma0(yma0), .chip_sel(chip_sel), .reg_num(reg_num)
  );

  always #5 fclk = ~fclk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    cyc = 0; wr_low = 0; cs1_falls = 0; cs1_low = 0; cs2_low = 0; rd_low = 0;
    conflicts = 0; first_cs = -1; last_cs = -1; first_wr = -1; last_wr = -1;
    wr_data = 8'h00; wr_a0 = 1'b0; prev_cs1 = ymcs1_n;
  endtask

  // One fclk cycle, sampled on the falling edge.
  task automatic step();
    @(negedge fclk);
    cyc++;
    if (!ymwr_n) begin
      wr_low++;
      wr_data = d_out;
      wr_a0   = yma0;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
    end
    if (!ymcs1_n || !ymcs2_n) begin
      if (first_cs < 0) first_cs = cyc;
      last_cs = cyc;
    end
    if (prev_cs1 && !ymcs1_n) cs1_falls++;
    if (!ymcs1_n) cs1_low++;
    if (!ymcs2_n) cs2_low++;
    if (!ymrd_n) rd_low++;
    if (!ymwr_n && !ymrd_n) conflicts++;
    if (!ymcs1_n && !ymcs2_n) conflicts++;
    prev_cs1 = ymcs1_n;
  endtask

  task automatic applyStimulus(input logic bdir, input logic bc1, input logic bc2,
                               input logic a8, input logic [7:0] data, input int active);
    aybdir = bdir; aybc1 = bc1; aybc2 = bc2; aya8 = a8; ayd_in = data;
    repeat (active) step();
    aybdir = 1'b0; aybc1 = 1'b0; aybc2 = 1'b1; aya8 = 1'b1;
    repeat (12) step();
  endtask

  initial begin
    ayres_n = 1'b0;
    aybdir = 1'b0; aybc1 = 1'b0; aybc2 = 1'b1; aya8 = 1'b1; aya9_n = 1'b0;
    ayd_in = 8'h00; d_in = 8'h00;
    #22;
    checkOutput("rst_wr_n", ymwr_n, 1);
    checkOutput("rst_cs_n", {ymcs1_n, ymcs2_n, ymrd_n}, 3'b111);
    checkOutput("rst_oe", {ayd_oe, d_oe, yma0, chip_sel}, 4'b0000);
    checkOutput("rst_reg_num", reg_num, 8'h00);
    checkOutput("rst_d_out", d_out, 8'h00);
    @(negedge fclk);
    ayres_n = 1'b1;
    repeat (3) step();

    // Address write 0x27 to chip 1
    clear_mon();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h27, 12);
    checkOutput("t1_cs1_falls", cs1_falls, 1);
    checkOutput("t1_wr_low", wr_low, 4);
    checkOutput("t1_a0", wr_a0, 0);
    checkOutput("t1_d_out", wr_data, 8'h27);
    checkOutput("t1_reg_num", reg_num, 8'h27);
    checkOutput("t1_cs2", cs2_low, 0);
    checkOutput("t1_conflicts", conflicts, 0);

    // Data write 0x55, with setup/hold timing
    clear_mon();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h55, 12);
    checkOutput("t2_wr_low", wr_low, 4);
    checkOutput("t2_a0", wr_a0, 1);
    checkOutput("t2_d_out", wr_data, 8'h55);
    checkOutput("t2_setup", first_wr - first_cs, 1);
    checkOutput("t2_hold", last_cs - last_wr, 2);
    checkOutput("t2_cs_len", cs1_low, 7);
    checkOutput("t2_reg_num", reg_num, 8'h27);

    // Chip-select control codes
    clear_mon();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'hFE, 12);
    checkOutput("t3_fe_wr", wr_low, 0);
    checkOutput("t3_fe_cs", cs1_low + cs2_low, 0);
    checkOutput("t3_chip_sel", chip_sel, 1);
    checkOutput("t3_fe_reg", reg_num, 8'h27);
    clear_mon();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'hAA, 12);
    checkOutput("t3_aa_cs2", cs2_low, 7);
    checkOutput("t3_aa_cs1", cs1_low, 0);
    checkOutput("t3_aa_wr", wr_low, 4);
    checkOutput("t3_aa_data", wr_data, 8'hAA);
    clear_mon();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 12);
    checkOutput("t3_ff_chip_sel", chip_sel, 0);
    checkOutput("t3_ff_wr", wr_low, 0);

    // Read with d_in = 0x80
    clear_mon();
    d_in = 8'h80;
    aybdir = 1'b0; aybc1 = 1'b1;
    repeat (10) step();
    checkOutput("t4_rd_n", ymrd_n, 0);
    checkOutput("t4_cs1_n", {ymcs1_n, ymcs2_n}, 2'b01);
    checkOutput("t4_ayd_oe", ayd_oe, 1);
    checkOutput("t4_ayd_out", ayd_out, 8'h80);
    checkOutput("t4_a0_doe", {yma0, d_oe}, 2'b10);
    checkOutput("t4_wr", wr_low, 0);
    aybc1 = 1'b0;
    repeat (3) step();
    checkOutput("t4_release", {ymrd_n, ymcs1_n, ymcs2_n, ayd_oe}, 4'b1110);
    checkOutput("t4_conflicts", conflicts, 0);
    repeat (4) step();

    // Reset during the strobe
    aybdir = 1'b1; aybc1 = 1'b1; ayd_in = 8'h33;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (!ymwr_n) found = 1'b1;
    end
    checkOutput("t5_strobe_seen", found, 1);
    step();
    #3 ayres_n = 1'b0;
    #1;
    checkOutput("t5_wr_n", ymwr_n, 1);
    checkOutput("t5_cs_n", {ymcs1_n, ymcs2_n}, 2'b11);
    checkOutput("t5_d_oe", d_oe, 0);
    checkOutput("t5_reg_num", reg_num, 8'h00);
    aybdir = 1'b0; aybc1 = 1'b0;
    step();
    step();
    ayres_n = 1'b1;
    clear_mon();
    repeat (20) step();
    checkOutput("t5_no_spurious", wr_low + cs1_low + cs2_low, 0);

    // Invalid bus qualifiers
    clear_mon();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h44, 12);
    checkOutput("t6_ref_reg", reg_num, 8'h44);
    clear_mon();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'h12, 12);
    checkOutput("t6_bc2_wr", wr_low + cs1_low + cs2_low, 0);
    checkOutput("t6_bc2_reg", reg_num, 8'h44);
    clear_mon();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h12, 12);
    checkOutput("t6_a8_wr", wr_low + cs1_low + cs2_low, 0);
    checkOutput("t6_a8_reg", reg_num, 8'h44);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
